// File: rtl/idu1_scoreboard_pkg.sv
// Shared decode/issue types: functional-unit ids and scoreboard sizing helpers.
package idu1_scoreboard_pkg;

  localparam int NUM_FU = 5;

  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_MUL = 3'd1,
    FU_MAC = 3'd2,
    FU_DIV = 3'd3,
    FU_LSU = 3'd4
  } fu_id_t;

  // Counter width able to hold 0..max inclusive.
  function automatic int ctr_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/idu1_scoreboard_fu_inflight_ctr.sv
// Per-unit outstanding-operation counter; never wraps in either direction.
module fu_inflight_ctr
  import idu1_scoreboard_pkg::*;
#(
  parameter bit PIPELINED = 1'b1,
  parameter int MAX       = 4,
  parameter int CW        = ctr_w(MAX)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic idle,
  output logic underflow
);

  logic [CW-1:0] count;
  logic          dec_ok;

  assign idle      = (count == '0);
  assign underflow = dec & idle;
  assign dec_ok    = dec & ~idle;
  // A blocking unit is "full" as soon as anything is outstanding.
  assign full      = PIPELINED ? (count == CW'(MAX)) : ~idle;

  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else if (inc & ~dec_ok)
      count <= count + 1'b1;
    else if (~inc & dec_ok)
      count <= count - 1'b1;
  end

endmodule

// File: rtl/idu1_scoreboard.sv
// Register + functional-unit scoreboard for the IDU1 issue slot: RAW/WAW and
// unit-occupancy hazard detection with same-cycle writeback bypass.
module idu1_scoreboard #(
  parameter int                NUM_REGS     = 32,
  parameter int                NUM_FU       = idu1_scoreboard_pkg::NUM_FU,
  parameter logic [NUM_FU-1:0] FU_PIPELINED = 5'b00111,
  parameter int                MAX_INFLIGHT = 4,
  localparam int               RW           = $clog2(NUM_REGS),
  localparam int               FW           = $clog2(NUM_FU),
  localparam int               CW           = idu1_scoreboard_pkg::ctr_w(MAX_INFLIGHT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [FW-1:0]       issue_fu,
  input  logic                issue_rs1_en,
  input  logic [RW-1:0]       issue_rs1_addr,
  input  logic                issue_rs2_en,
  input  logic [RW-1:0]       issue_rs2_addr,
  input  logic                issue_rd_en,
  input  logic [RW-1:0]       issue_rd_addr,
  input  logic                ext_stall,
  input  logic                pipe_flush,
  input  logic                wb_valid,
  input  logic [RW-1:0]       wb_rd_addr,
  input  logic [NUM_FU-1:0]   fu_done,
  output logic                issue_ready,
  output logic                pipe_stall,
  output logic                issue_fire,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [NUM_FU-1:0]   fu_idle,
  output logic                sb_err
);

  logic [NUM_REGS-1:0] busy, wb_mask, set_mask, eff_busy;
  logic [NUM_FU-1:0]   full_vec, inc_vec, uflow_vec;
  logic                raw1, raw2, waw, unit_haz, wb_err;

  for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
    assign inc_vec[f] = issue_fire & (issue_fu == FW'(f));
    fu_inflight_ctr #(
      .PIPELINED(FU_PIPELINED[f]),
      .MAX      (MAX_INFLIGHT),
      .CW       (CW)
    ) u_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (inc_vec[f]),
      .dec      (fu_done[f]),
      .full     (full_vec[f]),
      .idle     (fu_idle[f]),
      .underflow(uflow_vec[f])
    );
  end

  // Hazard side: a writeback landing this cycle is bypassed, so it hides busy.
  always_comb begin
    wb_mask = '0;
    if (wb_valid) wb_mask[wb_rd_addr] = 1'b1;
    eff_busy = busy & ~wb_mask;
    raw1     = issue_rs1_en & (issue_rs1_addr != '0) & eff_busy[issue_rs1_addr];
    raw2     = issue_rs2_en & (issue_rs2_addr != '0) & eff_busy[issue_rs2_addr];
    waw      = issue_rd_en  & (issue_rd_addr  != '0) & eff_busy[issue_rd_addr];
    unit_haz = 1'b0;
    if (int'(issue_fu) < NUM_FU)
      unit_haz = full_vec[issue_fu] & ~fu_done[issue_fu];
    wb_err   = wb_valid & (wb_rd_addr != '0) & ~busy[wb_rd_addr];
  end

  assign issue_ready = ~(raw1 | raw2 | waw | unit_haz);
  assign pipe_stall  = (issue_valid & ~issue_ready) | ext_stall;
  assign issue_fire  = issue_valid & issue_ready & ~ext_stall & ~pipe_flush;

  always_comb begin
    set_mask = '0;
    if (issue_fire & issue_rd_en & (issue_rd_addr != '0))
      set_mask[issue_rd_addr] = 1'b1;
  end

  // Issue set is OR'd after the writeback clear so it wins; x0 never sticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= '0;
      sb_err <= 1'b0;
    end else begin
      busy   <= ((busy & ~wb_mask) | set_mask) & ~NUM_REGS'(1);
      sb_err <= sb_err | wb_err | (|uflow_vec);
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_idu1_scoreboard.sv
// Directed test-plan scenarios plus randomized traffic against a reference model.
module tb_idu1_scoreboard;
  localparam int NR = 32, NF = 5, MX = 4;
  localparam logic [NF-1:0] PIPE = 5'b00111;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          issue_valid = 0, issue_rs1_en = 0, issue_rs2_en = 0, issue_rd_en = 0;
  logic [2:0]    issue_fu = '0;
  logic [4:0]    issue_rs1_addr = '0, issue_rs2_addr = '0, issue_rd_addr = '0, wb_rd_addr = '0;
  logic          ext_stall = 0, pipe_flush = 0, wb_valid = 0;
  logic [NF-1:0] fu_done = '0;
  logic          issue_ready, pipe_stall, issue_fire, sb_err;
  logic [NR-1:0] busy_vec;
  logic [NF-1:0] fu_idle;

  idu1_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_fu(issue_fu),
    .issue_rs1_en(issue_rs1_en), .issue_rs1_addr(issue_rs1_addr),
    .issue_rs2_en(issue_rs2_en), .issue_rs2_addr(issue_rs2_addr),
    .issue_rd_en(issue_rd_en), .issue_rd_addr(issue_rd_addr),
    .ext_stall(ext_stall), .pipe_flush(pipe_flush), .wb_valid(wb_valid),
    .wb_rd_addr(wb_rd_addr), .fu_done(fu_done), .issue_ready(issue_ready),
    .pipe_stall(pipe_stall), .issue_fire(issue_fire), .busy_vec(busy_vec),
    .fu_idle(fu_idle), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit mbusy[NR];
  int minf[NF];
  bit merr;
  bit last_fire, last_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit eff_busy(input int r);
    return r != 0 && mbusy[r] && !(wb_valid && int'(wb_rd_addr) == r);
  endfunction

  // One clock: drive, check combinational outputs, clock, advance model, check state.
  task automatic step(input bit v, input logic [2:0] fu, input bit r1e, input logic [4:0] r1,
                      input bit r2e, input logic [4:0] r2, input bit rde, input logic [4:0] rd,
                      input bit ext, input bit fl, input bit wbv, input logic [4:0] wba,
                      input logic [NF-1:0] done);
    bit haz, rdy, fire;
    logic [NR-1:0] eb;
    logic [NF-1:0] ei;
    int f;
    issue_valid = v; issue_fu = fu; issue_rs1_en = r1e; issue_rs1_addr = r1;
    issue_rs2_en = r2e; issue_rs2_addr = r2; issue_rd_en = rde; issue_rd_addr = rd;
    ext_stall = ext; pipe_flush = fl; wb_valid = wbv; wb_rd_addr = wba; fu_done = done;
    #2;
    f   = int'(fu);
    haz = (r1e && eff_busy(int'(r1))) || (r2e && eff_busy(int'(r2))) || (rde && eff_busy(int'(rd)));
    if (PIPE[f]) haz = haz || (minf[f] == MX && !done[f]);
    else         haz = haz || (minf[f] != 0 && !done[f]);
    rdy  = !haz;
    fire = v && rdy && !ext && !fl;
    chk("ready", 32'(issue_ready), 32'(rdy));
    chk("stall", 32'(pipe_stall), 32'((v && !rdy) || ext));
    chk("fire", 32'(issue_fire), 32'(fire));
    last_fire = issue_fire; last_stall = pipe_stall;
    @(posedge clk);
    if (!rst_n) begin
      foreach (mbusy[i]) mbusy[i] = 0;
      foreach (minf[i]) minf[i] = 0;
      merr = 0;
    end else begin
      for (int u = 0; u < NF; u++) begin
        if (done[u] && minf[u] == 0) merr = 1;
        else if (done[u]) minf[u]--;
        if (fire && u == f) minf[u]++;
      end
      if (wbv && wba != 0) begin
        if (!mbusy[wba]) merr = 1;
        mbusy[wba] = 0;
      end
      if (fire && rde && rd != 0) mbusy[rd] = 1;
    end
    #1;
    for (int i = 0; i < NR; i++) eb[i] = mbusy[i];
    for (int i = 0; i < NF; i++) ei[i] = (minf[i] == 0);
    chk("busy_vec", busy_vec, eb);
    chk("fu_idle", 32'(fu_idle), 32'(ei));
    chk("sb_err", 32'(sb_err), 32'(merr));
  endtask

  task automatic idle_cyc(input bit wbv = 0, input logic [4:0] wba = '0);
    step(0, 3'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, wbv, wba, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_cyc();
    rst_n = 1'b1;
    chk("rst_busy", busy_vec, '0);
    chk("rst_idle", 32'(fu_idle), 32'h1f);
    chk("rst_err", 32'(sb_err), 32'd0);
  endtask

  initial begin
    logic [NF-1:0] d;
    int nb, pick;
    logic [4:0] wa;
    foreach (minf[i]) minf[i] = 0;
    merr = 0;
    do_reset();

    // RAW on MUL result, released by bypass in the writeback cycle
    step(1, 3'd1, 0, 5'd0, 0, 5'd0, 1, 5'd5, 0, 0, 0, 5'd0, '0);
    chk("t1_mul_fire", 32'(last_fire), 32'd1);
    repeat (2) begin
      step(1, 3'd0, 1, 5'd5, 0, 5'd0, 1, 5'd6, 0, 0, 0, 5'd0, '0);
      chk("t1_raw_stall", 32'(last_stall), 32'd1);
    end
    step(1, 3'd0, 1, 5'd5, 0, 5'd0, 1, 5'd6, 0, 0, 1, 5'd5, '0);
    chk("t1_bypass_fire", 32'(last_fire), 32'd1);
    chk("t1_busy5_clear", 32'(busy_vec[5]), 32'd0);

    // blocking DIV
    do_reset();
    step(1, 3'd3, 0, 5'd0, 0, 5'd0, 1, 5'd10, 0, 0, 0, 5'd0, '0);
    step(1, 3'd3, 0, 5'd0, 0, 5'd0, 1, 5'd11, 0, 0, 0, 5'd0, '0);
    chk("t2_div_stall", 32'(last_stall), 32'd1);
    step(1, 3'd3, 0, 5'd0, 0, 5'd0, 1, 5'd11, 0, 0, 0, 5'd0, 5'b01000);
    chk("t2_div_fire", 32'(last_fire), 32'd1);
    chk("t2_div_busy", 32'(fu_idle[3]), 32'd0);

    // MUL saturation at MAX_INFLIGHT
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(1, 3'd1, 0, 5'd0, 0, 5'd0, 1, 5'(i), 0, 0, 0, 5'd0, '0);
      chk("t3_mul_fire", 32'(last_fire), 32'd1);
    end
    step(1, 3'd1, 0, 5'd0, 0, 5'd0, 1, 5'd5, 0, 0, 0, 5'd0, '0);
    chk("t3_mul5_stall", 32'(last_stall), 32'd1);
    step(1, 3'd1, 0, 5'd0, 0, 5'd0, 1, 5'd5, 0, 0, 0, 5'd0, 5'b00010);
    chk("t3_mul5_fire", 32'(last_fire), 32'd1);

    // same-cycle issue and writeback of x7: set wins
    do_reset();
    step(1, 3'd0, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 0, 0, 5'd0, '0);
    step(1, 3'd0, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 0, 1, 5'd7, '0);
    chk("t4_fire", 32'(last_fire), 32'd1);
    chk("t4_busy7", 32'(busy_vec[7]), 32'd1);

    // rd=x0, spurious writeback, reset recovery
    do_reset();
    step(1, 3'd0, 0, 5'd0, 0, 5'd0, 1, 5'd0, 0, 0, 0, 5'd0, '0);
    chk("t5_x0_busy", busy_vec, '0);
    idle_cyc(1, 5'd9);
    chk("t5_err_set", 32'(sb_err), 32'd1);
    idle_cyc();
    chk("t5_err_held", 32'(sb_err), 32'd1);
    do_reset();

    // ext_stall / pipe_flush leave state untouched
    step(1, 3'd1, 0, 5'd0, 0, 5'd0, 1, 5'd3, 1, 0, 0, 5'd0, '0);
    chk("t6_ext_nofire", 32'(last_fire), 32'd0);
    chk("t6_ext_busy", busy_vec, '0);
    step(1, 3'd1, 0, 5'd0, 0, 5'd0, 1, 5'd3, 0, 1, 0, 5'd0, '0);
    chk("t6_flush_nofire", 32'(last_fire), 32'd0);
    chk("t6_flush_idle", 32'(fu_idle), 32'h1f);

    // randomized legal traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      d = '0;
      for (int u = 0; u < NF; u++)
        if (minf[u] > 0 && $urandom_range(0, 2) == 0) d[u] = 1'b1;
      nb = 0;
      for (int r = 1; r < NR; r++) if (mbusy[r]) nb++;
      wa = '0;
      if (nb > 0 && $urandom_range(0, 1) == 1) begin
        pick = $urandom_range(0, nb - 1);
        for (int r = 1; r < NR; r++)
          if (mbusy[r]) begin
            if (pick == 0) wa = 5'(r);
            pick--;
          end
      end
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 4)),
           1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
           1'($urandom), 5'($urandom_range(0, 7)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           wa != 0, wa, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
